uart_frame_router: RTL and testbench

UART_FRAME_ROUTER -- requirements
Module: uart_frame_router

---
 rtl/uart_frame_router_if.sv | 35 +++
 rtl/uart_frame_router.sv | 159 +++++++++++++++
 tb/tb_uart_frame_router.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_router_if.sv
// Byte-in / strobe-out bundle of the UART frame router.
// The slave modport is the router; the master modport is the byte source and strobe consumer.
interface uart_frame_router_if #(
    parameter int NUM_CHANNEL  = 4,
    parameter int CH_WORDS     = 8,
    parameter int LAUNCH_WORDS = 4
);
    localparam int AW = (CH_WORDS > 1) ? $clog2(CH_WORDS) : 1;

    logic [7:0]                 i_rx_data;
    logic                       i_rx_valid;
    logic [NUM_CHANNEL-1:0]     o_wr_en;
    logic [AW-1:0]              o_wr_addr;
    logic [31:0]                o_wr_data;
    logic                       o_launch;
    logic [NUM_CHANNEL-1:0]     o_launch_mask;
    logic [LAUNCH_WORDS*32-1:0] o_launch_regs;
    logic                       o_err_hdr;
    logic                       o_err_timeout;
    logic                       o_busy;
    logic [1:0]                 o_dbg_state;

    // i_rx_valid is a one-cycle strobe with no back-pressure: every strobed byte is consumed.
    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_wr_en, o_wr_addr, o_wr_data, o_launch, o_launch_mask, o_launch_regs,
               o_err_hdr, o_err_timeout, o_busy, o_dbg_state
    );

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_wr_en, o_wr_addr, o_wr_data, o_launch, o_launch_mask, o_launch_regs,
               o_err_hdr, o_err_timeout, o_busy, o_dbg_state
    );
endinterface

// File: rtl/uart_frame_router.sv
// Assembles UART bytes into 32-bit words and routes header-selected frames either to a
// channel register file (one write per word) or to an atomically committed launch buffer.
module uart_frame_router #(
    parameter int NUM_CHANNEL    = 4,
    parameter int CH_WORDS       = 8,
    parameter int LAUNCH_WORDS   = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    uart_frame_router_if.slave bus
);
    localparam int AW   = (CH_WORDS > 1) ? $clog2(CH_WORDS) : 1;
    localparam int CW   = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam int LW   = (LAUNCH_WORDS > 1) ? $clog2(LAUNCH_WORDS) : 1;
    localparam int MAXW = (CH_WORDS > LAUNCH_WORDS) ? CH_WORDS : LAUNCH_WORDS;
    localparam int IW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES);
    localparam int RW   = LAUNCH_WORDS * 32;

    typedef enum logic [1:0] {
        ST_HDR        = 2'd0,
        ST_CH_PAY     = 2'd1,
        ST_LAUNCH_PAY = 2'd2
    } state_e;

    state_e                 state_q;
    logic [1:0]             byte_cnt_q;
    logic [23:0]            asm_q;
    logic [CW-1:0]          chan_q;
    logic [IW-1:0]          widx_q;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [31:0]            shadow_q [LAUNCH_WORDS];
    logic [NUM_CHANNEL-1:0] wr_en_q;
    logic [AW-1:0]          wr_addr_q;
    logic [31:0]            wr_data_q;
    logic                   launch_q;
    logic [NUM_CHANNEL-1:0] launch_mask_q;
    logic [RW-1:0]          launch_regs_q, launch_regs_d;
    logic                   err_hdr_q;
    logic                   err_tmo_q;

    logic                   busy;
    logic                   word_done;
    logic                   tmo_expire;
    logic [31:0]            word_in;
    logic                   hdr_hit;
    logic [CW-1:0]          hdr_idx;

    assign busy       = (byte_cnt_q != 2'd0) || (state_q != ST_HDR);
    assign word_in    = {asm_q, bus.i_rx_data};
    assign word_done  = bus.i_rx_valid && (byte_cnt_q == 2'd3);
    // A byte on the expiring cycle clears the counter instead of timing out.
    assign tmo_expire = busy && !bus.i_rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        hdr_hit = 1'b0;
        hdr_idx = '0;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            if (word_in == (32'hFFFF_FFFF ^ (32'd1 << (i + 8)))) begin
                hdr_hit = 1'b1;
                hdr_idx = CW'(i);
            end
        end
    end

    always_comb begin
        if (bus.i_rx_valid || !busy || tmo_expire) tmo_d = '0;
        else                                       tmo_d = tmo_q + TW'(1);
    end

    // Commit image: shadow words with the word completing right now spliced in.
    always_comb begin
        launch_regs_d = '0;
        for (int k = 0; k < LAUNCH_WORDS; k++) begin
            launch_regs_d[32*k +: 32] = (widx_q[LW-1:0] == LW'(k)) ? word_in : shadow_q[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_HDR;
            byte_cnt_q    <= '0;
            asm_q         <= '0;
            chan_q        <= '0;
            widx_q        <= '0;
            tmo_q         <= '0;
            for (int k = 0; k < LAUNCH_WORDS; k++) shadow_q[k] <= '0;
            wr_en_q       <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            launch_q      <= 1'b0;
            launch_mask_q <= '0;
            launch_regs_q <= '0;
            err_hdr_q     <= 1'b0;
            err_tmo_q     <= 1'b0;
        end else begin
            wr_en_q   <= '0;
            launch_q  <= 1'b0;
            err_hdr_q <= 1'b0;
            err_tmo_q <= 1'b0;
            tmo_q     <= tmo_d;
            if (tmo_expire) begin
                err_tmo_q  <= 1'b1;
                state_q    <= ST_HDR;
                byte_cnt_q <= '0;
            end else if (bus.i_rx_valid) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                asm_q      <= {asm_q[15:0], bus.i_rx_data};
                if (word_done) begin
                    case (state_q)
                        ST_HDR: begin
                            if (word_in == 32'hFFFF_FFFF) begin
                                state_q <= ST_LAUNCH_PAY;
                                widx_q  <= '0;
                            end else if (hdr_hit) begin
                                state_q <= ST_CH_PAY;
                                chan_q  <= hdr_idx;
                                widx_q  <= '0;
                            end else begin
                                err_hdr_q <= 1'b1;
                            end
                        end
                        ST_CH_PAY: begin
                            wr_en_q   <= NUM_CHANNEL'(1) << chan_q;
                            wr_addr_q <= widx_q[AW-1:0];
                            wr_data_q <= word_in;
                            if (widx_q == IW'(CH_WORDS - 1)) state_q <= ST_HDR;
                            else                             widx_q  <= widx_q + IW'(1);
                        end
                        ST_LAUNCH_PAY: begin
                            shadow_q[widx_q[LW-1:0]] <= word_in;
                            if (widx_q == IW'(LAUNCH_WORDS - 1)) begin
                                launch_regs_q <= launch_regs_d;
                                launch_mask_q <= launch_regs_d[NUM_CHANNEL-1:0];
                                launch_q      <= 1'b1;
                                state_q       <= ST_HDR;
                            end else begin
                                widx_q <= widx_q + IW'(1);
                            end
                        end
                        default: state_q <= ST_HDR;
                    endcase
                end
            end
        end
    end

    assign bus.o_wr_en       = wr_en_q;
    assign bus.o_wr_addr     = wr_addr_q;
    assign bus.o_wr_data     = wr_data_q;
    assign bus.o_launch      = launch_q;
    assign bus.o_launch_mask = launch_mask_q;
    assign bus.o_launch_regs = launch_regs_q;
    assign bus.o_err_hdr     = err_hdr_q;
    assign bus.o_err_timeout = err_tmo_q;
    assign bus.o_busy        = busy;
    assign bus.o_dbg_state   = state_q;
endmodule

// File: tb/tb_uart_frame_router.sv
// Bench for uart_frame_router: directed frames plus random traffic, with a frame-level
// reference model feeding expected-strobe queues that a negedge monitor drains.
module tb_uart_frame_router;
    localparam int NC  = 4;
    localparam int CWD = 8;
    localparam int LWD = 4;
    localparam int TMO = 64;
    localparam int AW  = 3;
    localparam int WR_W = 32 + NC + AW + 32;
    localparam int LA_W = 32 + NC + LWD * 32;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    uart_frame_router_if #(.NUM_CHANNEL(NC), .CH_WORDS(CWD), .LAUNCH_WORDS(LWD)) bus ();

    uart_frame_router #(
        .NUM_CHANNEL(NC), .CH_WORDS(CWD), .LAUNCH_WORDS(LWD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [WR_W-1:0] exp_wr_q[$];
    logic [LA_W-1:0] exp_launch_q[$];
    logic [31:0]     exp_hdr_q[$];
    logic [31:0]     exp_tmo_q[$];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name, input logic [191:0] act);
        n_checks++;
        $display("FAIL %s: unexpected strobe at cycle %0d, got %0h, required none", name, cyc, act);
    endtask

    function automatic logic [191:0] all_outputs();
        return {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_launch, bus.o_launch_mask,
                bus.o_launch_regs, bus.o_err_hdr, bus.o_err_timeout, bus.o_busy, bus.o_dbg_state};
    endfunction

    always @(negedge clk) begin
        if (bus.o_wr_en != '0) begin
            if (exp_wr_q.size() == 0) unexpected("wr", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data});
            else check("wr", {cyc, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}, exp_wr_q.pop_front());
        end
        if (bus.o_launch) begin
            if (exp_launch_q.size() == 0) unexpected("launch", bus.o_launch_regs);
            else check("launch", {cyc, bus.o_launch_mask, bus.o_launch_regs}, exp_launch_q.pop_front());
        end
        if (bus.o_err_hdr) begin
            if (exp_hdr_q.size() == 0) unexpected("err_hdr", 192'(cyc));
            else check("err_hdr", 192'(cyc), exp_hdr_q.pop_front());
        end
        if (bus.o_err_timeout) begin
            if (exp_tmo_q.size() == 0) unexpected("err_timeout", 192'(cyc));
            else check("err_timeout", 192'(cyc), exp_tmo_q.pop_front());
        end
    end

    // ---------------- reference model (frame level) ----------------
    logic [31:0]       m_acc;
    int                m_nb, m_mode, m_ch, m_widx, m_idle;  // m_mode: 0 header, 1 channel, 2 launch
    logic [31:0]       m_shadow [LWD];
    logic [LWD*32-1:0] m_regs;

    // -1 launch header, -2 rejected header, otherwise channel number
    function automatic int classify(input logic [31:0] w);
        int pos;
        if (w == 32'hFFFF_FFFF) return -1;
        if (w[7:0] != 8'hFF || $countones(~w) != 1) return -2;
        pos = 0;
        for (int p = 8; p < 32; p++) if (!w[p]) pos = p;
        return (pos - 8 < NC) ? pos - 8 : -2;
    endfunction

    function automatic bit m_busy();
        return (m_nb != 0) || (m_mode != 0);
    endfunction

    task automatic model_reset();
        m_acc = '0; m_nb = 0; m_mode = 0; m_ch = 0; m_widx = 0; m_idle = 0; m_regs = '0;
        for (int k = 0; k < LWD; k++) m_shadow[k] = '0;
    endtask

    task automatic model_byte(input logic [7:0] b, input int stamp);
        int c;
        m_idle = 0;
        m_acc  = {m_acc[23:0], b};
        m_nb++;
        if (m_nb == 4) begin
            m_nb = 0;
            if (m_mode == 0) begin
                c = classify(m_acc);
                if (c == -1) begin m_mode = 2; m_widx = 0; end
                else if (c >= 0) begin m_mode = 1; m_ch = c; m_widx = 0; end
                else exp_hdr_q.push_back(stamp);
            end else if (m_mode == 1) begin
                exp_wr_q.push_back({stamp, NC'(1) << m_ch, AW'(m_widx), m_acc});
                m_widx++;
                if (m_widx == CWD) m_mode = 0;
            end else begin
                m_shadow[m_widx] = m_acc;
                m_widx++;
                if (m_widx == LWD) begin
                    for (int k = 0; k < LWD; k++) m_regs[32*k +: 32] = m_shadow[k];
                    exp_launch_q.push_back({stamp, m_regs[NC-1:0], m_regs});
                    m_mode = 0;
                end
            end
        end
    endtask

    task automatic model_idle(input int stamp);
        if (m_busy()) begin
            m_idle++;
            if (m_idle == TMO) begin
                exp_tmo_q.push_back(stamp);
                m_nb = 0; m_mode = 0; m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        model_byte(b, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("busy", 192'(bus.o_busy), 192'(m_busy()));
            bus.i_rx_valid = 1'b0;
            bus.i_rx_data  = 8'($urandom);
            model_idle(cyc + 1);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
            drive_byte(w[31-8*i -: 8]);
        end
    endtask

    task automatic send_ch_frame(input int ch, input bit gaps, input bit incr);
        send_word(32'hFFFF_FFFF ^ (32'd1 << (ch + 8)), gaps);
        for (int n = 0; n < CWD; n++) send_word(incr ? 32'(n + 1) : $urandom, gaps);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_rx_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_outputs", all_outputs(), '0);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), '0);
        rst_n = 1'b1;
        idle(2);

        // Channel 2 frame with payload 1..8, back to back.
        send_ch_frame(2, 1'b0, 1'b1);
        idle(3);

        // Launch frame; mask from word 0, word 1 lands at [63:32].
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_000F, 1'b0);
        send_word(32'h0000_0064, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        idle(3);
        check("launch_mask", 192'(bus.o_launch_mask), 192'(4'hF));
        check("launch_word1", 192'(bus.o_launch_regs[63:32]), 192'(32'h64));

        // Rejected headers, then a good channel-0 frame.
        send_word(32'hFFFF_00FF, 1'b0);
        idle(2);
        send_word(32'hFFFF_EFFF, 1'b0);
        idle(2);
        send_ch_frame(0, 1'b1, 1'b0);
        idle(3);

        // Launch frame aborted by timeout after 5 payload bytes.
        send_word(32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom));
        idle(TMO);
        idle(1);
        check("tmo_busy", 192'(bus.o_busy), 192'(1'b0));
        check("tmo_regs_kept", 192'(bus.o_launch_regs), 192'({32'h0, 32'h0, 32'h64, 32'hF}));
        check("tmo_mask_kept", 192'(bus.o_launch_mask), 192'(4'hF));
        send_word(32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < LWD; i++) send_word($urandom, 1'b0);
        idle(3);

        // Byte arriving exactly on the last idle cycle keeps the frame alive.
        send_word(32'hFFFF_F7FF, 1'b0);
        drive_byte(8'hA5);
        idle(TMO - 1);
        drive_byte(8'h5A);
        drive_byte(8'h3C);
        drive_byte(8'hC3);
        for (int n = 1; n < CWD; n++) send_word($urandom, 1'b0);
        idle(3);

        // Reset after three channel-1 words, then a fresh channel-1 frame.
        send_word(32'hFFFF_FDFF, 1'b0);
        for (int n = 0; n < 3; n++) send_word($urandom, 1'b0);
        drive_byte(8'h11);
        idle(1);
        do_reset();
        send_ch_frame(1, 1'b0, 1'b0);
        idle(3);

        // Random traffic.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: send_ch_frame($urandom_range(0, NC - 1), 1'b1, 1'b0);
                6, 7: begin
                    send_word(32'hFFFF_FFFF, 1'b1);
                    for (int n = 0; n < LWD; n++) send_word($urandom, 1'b1);
                end
                8: send_word($urandom, 1'b1);
                default: begin
                    if ($urandom_range(0, 1) == 0) send_word(32'hFFFF_FFFF, 1'b0);
                    else send_word(32'hFFFF_FFFF ^ (32'd1 << ($urandom_range(0, NC - 1) + 8)), 1'b0);
                    for (int i = 0; i < $urandom_range(1, 10); i++) drive_byte(8'($urandom));
                    idle(TMO + 2);
                end
            endcase
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end

        idle(10);
        check("wr_queue_drained", 192'(exp_wr_q.size()), 192'(0));
        check("launch_queue_drained", 192'(exp_launch_q.size()), 192'(0));
        check("hdr_queue_drained", 192'(exp_hdr_q.size()), 192'(0));
        check("tmo_queue_drained", 192'(exp_tmo_q.size()), 192'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
